// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: picks one eligible slave channel per packet by priority with
// round-robin tie-break, then streams exactly the decoded packet length to the formatter.
module mcdf_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          slv0_en_i,
  input  logic          slv1_en_i,
  input  logic          slv2_en_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    slv0_pkglen_i,
  input  logic [2:0]    slv1_pkglen_i,
  input  logic [2:0]    slv2_pkglen_i,
  input  logic          slv0_req_i,
  input  logic          slv1_req_i,
  input  logic          slv2_req_i,
  input  logic          slv0_val_i,
  input  logic          slv1_val_i,
  input  logic          slv2_val_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  output logic          slv0_ack_o,
  output logic          slv1_ack_o,
  output logic          slv2_ack_o,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_id_o,
  output logic [5:0]    fmt_len_o,
  input  logic          fmt_ready_i,
  output logic          fmt_val_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;

  logic [1:0]          state, id, rr_ptr;
  logic [5:0]          len, beat_cnt;
  logic [2:0]          en, req, val, elig, ack;
  logic [2:0][1:0]     prio;
  logic [2:0][2:0]     pkglen;
  logic [2:0][DW-1:0]  data;
  logic                win_vld, in_xfer, beat, last;
  logic [1:0]          win_id, best, ch;
  logic [2:0]          sum;

  assign en     = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign req    = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign val    = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign prio   = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign pkglen = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};
  assign data   = {slv2_data_i, slv1_data_i, slv0_data_i};
  assign elig   = en & req;

  function automatic logic [5:0] len_dec(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Scan starting at rr_ptr; strict '<' keeps the first tied channel in scan order.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    best    = 2'd3;
    sum     = 3'd0;
    ch      = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      ch  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (elig[ch] && (!win_vld || prio[ch] < best)) begin
        win_vld = 1'b1;
        win_id  = ch;
        best    = prio[ch];
      end
    end
  end

  assign in_xfer     = (state == XFER);
  assign beat        = in_xfer & fmt_ready_i & val[id];
  assign last        = (beat_cnt == len - 6'd1);
  assign ack         = beat ? (3'b001 << id) : 3'b000;
  assign slv0_ack_o  = ack[0];
  assign slv1_ack_o  = ack[1];
  assign slv2_ack_o  = ack[2];
  assign fmt_req_o   = (state == REQ);
  assign fmt_id_o    = id;
  assign fmt_len_o   = len;
  assign fmt_val_o   = in_xfer & val[id];
  assign fmt_data_o  = in_xfer ? data[id] : '0;
  assign fmt_start_o = beat & (beat_cnt == 6'd0);
  assign fmt_end_o   = beat & last;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      id       <= 2'd0;
      len      <= 6'd0;
      beat_cnt <= 6'd0;
      rr_ptr   <= 2'd0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          id    <= win_id;
          len   <= len_dec(pkglen[win_id]);
          state <= REQ;
        end
        REQ: if (fmt_grant_i) state <= XFER;
        XFER: if (beat) begin
          if (last) begin
            state    <= IDLE;
            beat_cnt <= 6'd0;
            rr_ptr   <= (id == 2'd2) ? 2'd0 : id + 2'd1;
          end else begin
            beat_cnt <= beat_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: expected beats are queued per packet and
// popped by a negedge monitor that checks data, start/end flags and acks.
module tb_mcdf_arbiter;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, grant, ready;
  logic [2:0]    en, req, val, ack;
  logic [1:0]    prio [3];
  logic [2:0]    pkglen [3];
  logic [23:0]   cnt [3] = '{24'd0, 24'd0, 24'd0};
  logic          fmt_req, fmt_val, fmt_start, fmt_end;
  logic [1:0]    fmt_id;
  logic [5:0]    fmt_len;
  logic [DW-1:0] fmt_data;

  int    errors = 0, checks = 0;
  int    exp_cnt [3] = '{0, 0, 0};
  int    ackc [3] = '{0, 0, 0};
  int    ack_base;
  bit    prev_end = 1'b0;
  beat_t q[$];

  // Each slave source emits {channel, running word count} and pops on ack.
  always @(posedge clk)
    for (int n = 0; n < 3; n++) cnt[n] <= cnt[n] + 24'(ack[n]);

  mcdf_arbiter #(.DW(DW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_en_i(en[0]), .slv1_en_i(en[1]), .slv2_en_i(en[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .slv0_pkglen_i(pkglen[0]), .slv1_pkglen_i(pkglen[1]), .slv2_pkglen_i(pkglen[2]),
    .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
    .slv0_val_i(val[0]), .slv1_val_i(val[1]), .slv2_val_i(val[2]),
    .slv0_data_i({8'd0, cnt[0]}), .slv1_data_i({8'd1, cnt[1]}), .slv2_data_i({8'd2, cnt[2]}),
    .slv0_ack_o(ack[0]), .slv1_ack_o(ack[1]), .slv2_ack_o(ack[2]),
    .fmt_req_o(fmt_req), .fmt_grant_i(grant), .fmt_id_o(fmt_id), .fmt_len_o(fmt_len),
    .fmt_ready_i(ready), .fmt_val_o(fmt_val), .fmt_data_o(fmt_data),
    .fmt_start_o(fmt_start), .fmt_end_o(fmt_end)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bound(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
    end
  endtask

  // Monitor: every committed beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (!rstn) prev_end = 1'b0;
    else begin
      if (prev_end) chk("idle_gap_req", {63'd0, fmt_req}, 64'd0);
      prev_end = 1'b0;
      if (fmt_val && ready) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=beat expected=none data=%0h", fmt_data);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("beat_data", fmt_data, e.data);
          chk("beat_start_end", {fmt_start, fmt_end}, {e.first, e.last});
          chk("beat_ack", ack, 3'b001 << e.id);
          prev_end = e.last;
        end
      end else begin
        chk("no_beat_ack_start_end", {ack, fmt_start, fmt_end}, 5'd0);
      end
      for (int n = 0; n < 3; n++) ackc[n] += int'(ack[n]);
    end
  end

  task automatic start_pkt(input int n, input int l, input string tag);
    bit got = 1'b0;
    beat_t b;
    for (int i = 0; i < l; i++) begin
      b.id    = 2'(n);
      b.data  = {8'(n), 24'(exp_cnt[n] + i)};
      b.first = (i == 0);
      b.last  = (i == l - 1);
      q.push_back(b);
    end
    exp_cnt[n] += l;
    ack_base = ackc[n];
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); #1;
      if (fmt_req) got = 1'b1;
    end
    bound({tag, "_req_wait"}, got);
    chk({tag, "_id"}, fmt_id, n);
    chk({tag, "_len"}, fmt_len, l);
  endtask

  task automatic finish_pkt(input int n, input int l, input string tag, input bit rnd);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0) done = 1'b1;
      else if (rnd) begin
        ready  = 1'($urandom);
        val[0] = 1'($urandom);
      end
    end
    bound({tag, "_done_wait"}, done);
    chk({tag, "_ack_count"}, ackc[n] - ack_base, l);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {fmt_req, fmt_id, fmt_len, fmt_val, fmt_data, fmt_start, fmt_end, ack}, 0);
  endtask

  initial begin
    int codes [4] = '{1, 2, 3, 7};
    int lens  [4] = '{8, 16, 32, 32};
    bit hit;
    string order_tag;
    int order [4] = '{0, 1, 2, 0};

    // 1: reset with everything requesting
    rstn = 1'b0; grant = 1'b0; ready = 1'b1;
    en = 3'b111; req = 3'b111; val = 3'b111;
    for (int n = 0; n < 3; n++) begin prio[n] = 2'd0; pkglen[n] = 3'd0; end
    repeat (2) @(posedge clk); #1;
    chk_zero("reset_outputs");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("reset_release_req", {63'd0, fmt_req}, 64'd1);
    chk("reset_release_id_len", {fmt_id, fmt_len}, {2'd0, 6'd4});

    // 2: priority 3/1/2 -> ch1
    rstn = 1'b0; #1;
    prio[0] = 2'd3; prio[1] = 2'd1; prio[2] = 2'd2;
    grant = 1'b1;
    rstn = 1'b1;
    start_pkt(1, 4, "prio");
    finish_pkt(1, 4, "prio", 1'b0);
    req = 3'b000;
    repeat (3) @(posedge clk); #1;
    chk("prio_idle_req_data", {fmt_req, fmt_data}, 0);

    // 3: equal priorities rotate 0,1,2,0
    rstn = 1'b0; #1;
    for (int n = 0; n < 3; n++) prio[n] = 2'd0;
    rstn = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      order_tag = $sformatf("rr%0d", k);
      start_pkt(order[k], 4, order_tag);
      finish_pkt(order[k], 4, order_tag, 1'b0);
    end
    req = 3'b000;
    repeat (3) @(posedge clk); #1;

    // 4: length codes on ch0
    req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      pkglen[0] = 3'(codes[k]);
      order_tag = $sformatf("len_code%0d", codes[k]);
      start_pkt(0, lens[k], order_tag);
      finish_pkt(0, lens[k], order_tag, 1'b0);
    end
    req = 3'b000;
    repeat (3) @(posedge clk); #1;

    // 5: random ready/valid stalls over a 16-beat packet
    pkglen[0] = 3'd2; req = 3'b001;
    start_pkt(0, 16, "stall");
    finish_pkt(0, 16, "stall", 1'b1);
    req = 3'b000; ready = 1'b1; val = 3'b111;
    repeat (3) @(posedge clk); #1;

    // 6a: config and enable changes mid-packet are ignored
    req = 3'b001;
    start_pkt(0, 16, "mid");
    repeat (3) @(posedge clk); #1;
    en[0] = 1'b0; req[0] = 1'b0; prio[0] = 2'd3; pkglen[0] = 3'd0;
    chk("mid_len_held", {fmt_id, fmt_len}, {2'd0, 6'd16});
    finish_pkt(0, 16, "mid", 1'b0);
    repeat (3) @(posedge clk); #1;

    // 6b: reset at beat 5 aborts; next packet starts from beat 0
    en[0] = 1'b1; req[0] = 1'b1; prio[0] = 2'd0; pkglen[0] = 3'd2;
    start_pkt(0, 16, "abort");
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (ackc[0] - ack_base == 5) hit = 1'b1;
    end
    bound("abort_beat5_wait", hit);
    rstn = 1'b0; #1;
    chk_zero("abort_outputs");
    q.delete();
    exp_cnt[0] = exp_cnt[0] - 16 + 5;
    @(posedge clk); #1;
    rstn = 1'b1;
    start_pkt(0, 16, "restart");
    finish_pkt(0, 16, "restart", 1'b0);
    req = 3'b000;
    repeat (3) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
